blink_meter: RTL and testbench

Measures the waveform on a single slow digital input, such as an LED blink line or another board's heartbeat. It synchronises the input and counts clock cycles between edges. Each complete cycle yields a period and high-time measurement through a valid/ready handshake. The block sits on the receive side of a blink/heartbeat link, alongside the counter-based blink generators. It also flags a stalled input and dropped results.

---
 rtl/blink_meter.sv | 120 ++++++++++++
 tb/tb_blink_meter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/blink_meter.sv
// Period / high-time meter for a slow asynchronous input; results leave on a valid/ready port.
// Result valid SYNC_STAGES+1 cycles after the closing input edge; a result arriving while one is still held is dropped and flagged in overrun.
module blink_meter #(
  parameter int CNT_W       = 26,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             blink_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic             stuck,
  output logic             overrun,
  input  logic             clr_overrun
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic                   s_d;
  logic                   rise;
  logic                   fall;
  logic                   cnt_sat;
  logic                   emit;
  logic                   load;
  logic                   drop;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       high_cap;

  assign s       = sync_q[SYNC_STAGES-1];
  assign rise    = s & ~s_d;
  assign fall    = ~s & s_d;
  assign cnt_sat = (cnt == CNT_MAX);

  // A closing rise on a saturated count means the period is out of range, so it never becomes a result.
  assign emit = (state == MEAS_LOW) && rise && !cnt_sat;
  assign load = emit && (!meas_valid || meas_ready);
  assign drop = emit && meas_valid && !meas_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= WAIT_RISE;
      sync_q     <= '0;
      s_d        <= 1'b0;
      cnt        <= '0;
      high_cap   <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      stuck      <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], blink_in};
      s_d    <= s;

      if (rise) begin
        cnt <= CNT_W'(1);
      end else if (!cnt_sat) begin
        cnt <= cnt + CNT_W'(1);
      end

      case (state)
        WAIT_RISE: begin
          if (rise) begin
            state <= MEAS_HIGH;
          end
        end
        MEAS_HIGH: begin
          if (fall) begin
            high_cap <= cnt;
            state    <= MEAS_LOW;
          end else if (cnt_sat) begin
            stuck <= 1'b1;
            state <= WAIT_RISE;
          end
        end
        MEAS_LOW: begin
          if (rise) begin
            state <= MEAS_HIGH;
          end else if (cnt_sat) begin
            stuck <= 1'b1;
            state <= WAIT_RISE;
          end
        end
        default: begin
          state <= WAIT_RISE;
        end
      endcase

      if (rise) begin
        stuck <= 1'b0;
      end

      if (load) begin
        period     <= cnt;
        high_time  <= high_cap;
        meas_valid <= 1'b1;
      end else if (meas_valid && meas_ready) begin
        meas_valid <= 1'b0;
      end

      if (drop) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_blink_meter.sv
// Bench for blink_meter: timestamp-based reference model checked every cycle, plus directed scenario checks.
module tb_blink_meter;

  localparam int CW   = 6;
  localparam int SS   = 2;
  localparam int MAXC = (1 << CW) - 1;

  logic          clk;
  logic          rst;
  logic          blink_in;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          meas_valid;
  logic          meas_ready;
  logic          stuck;
  logic          overrun;
  logic          clr_overrun;

  blink_meter #(.CNT_W(CW), .SYNC_STAGES(SS)) dut (
    .clk         (clk),
    .rst         (rst),
    .blink_in    (blink_in),
    .period      (period),
    .high_time   (high_time),
    .meas_valid  (meas_valid),
    .meas_ready  (meas_ready),
    .stuck       (stuck),
    .overrun     (overrun),
    .clr_overrun (clr_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int per;
    int hi;
  } res_t;
  res_t acc[$];

  // Reference model: edge timestamps of the synchronised input, results as timestamp differences.
  int  edge_k = 0;
  bit  live   = 0;
  bit  hist[$];
  bit  m_meas;
  int  m_r;
  int  m_f;
  bit  m_valid;
  bit  m_stuck;
  bit  m_ovr;
  int  m_per;
  int  m_high;

  always @(posedge clk) begin
    bit sv, sdv, rs, fl, res_ok, drop;
    int per, hi;
    edge_k++;
    if (!rst) begin
      hist.delete();
      for (int i = 0; i <= SS; i++) hist.push_back(1'b0);
      m_meas = 0; m_valid = 0; m_stuck = 0; m_ovr = 0;
      m_per = 0; m_high = 0; m_r = 0; m_f = 0;
      live = 1;
    end else if (live) begin
      sv     = hist[SS-1];
      sdv    = hist[SS];
      rs     = sv & !sdv;
      fl     = !sv & sdv;
      res_ok = 0;
      drop   = 0;
      per    = 0;
      hi     = 0;
      if (rs) begin
        if (m_meas && m_f > m_r && (edge_k - m_r) < MAXC) begin
          res_ok = 1;
          per    = edge_k - m_r;
          hi     = m_f - m_r;
        end
        m_meas  = 1;
        m_r     = edge_k;
        m_f     = edge_k;
        m_stuck = 0;
      end else if (fl) begin
        if (m_meas) m_f = edge_k;
      end else if (m_meas && (edge_k - m_r) >= MAXC) begin
        m_meas  = 0;
        m_stuck = 1;
      end
      if (res_ok) begin
        if (!m_valid || meas_ready) begin
          m_valid = 1;
          m_per   = per;
          m_high  = hi;
        end else begin
          drop = 1;
        end
      end else if (m_valid && meas_ready) begin
        m_valid = 0;
      end
      if (drop) m_ovr = 1;
      else if (clr_overrun) m_ovr = 0;
      hist.push_front(blink_in);
      void'(hist.pop_back());
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (live) begin
      chk("m_valid", meas_valid, m_valid);
      chk("m_period", period, m_per);
      chk("m_high", high_time, m_high);
      chk("m_stuck", stuck, m_stuck);
      chk("m_overrun", overrun, m_ovr);
      if (meas_valid && meas_ready) begin
        r.per = int'(period);
        r.hi  = int'(high_time);
        acc.push_back(r);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_wave(input int hi, input int lo, input int reps);
    repeat (reps) begin
      blink_in = 1'b1;
      cyc(hi);
      blink_in = 1'b0;
      cyc(lo);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    cyc(2);
    rst = 1'b1;
  endtask

  task automatic chk_acc(input string tag, input int n, input int per, input int hi);
    chk({tag, "_count"}, acc.size(), n);
    foreach (acc[i]) begin
      chk({tag, "_period"}, acc[i].per, per);
      chk({tag, "_high"}, acc[i].hi, hi);
    end
  endtask

  function automatic int jit();
    int r;
    r = $urandom_range(0, 8);
    if (r >= 5) r++;
    return r;
  endfunction

  initial begin
    time base, t;
    int  len;
    bit  lvl;
    rst = 1'b0; blink_in = 1'b0; meas_ready = 1'b0; clr_overrun = 1'b0;

    // reset held with the input toggling
    cyc(1);
    repeat (3) begin
      blink_in = ~blink_in;
      cyc(1);
    end
    @(negedge clk);
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_valid", meas_valid, 0);
    chk("rst_stuck", stuck, 0);
    chk("rst_overrun", overrun, 0);
    cyc(1);
    rst = 1'b1; blink_in = 1'b0;
    cyc(3);

    // steady 5/3 wave, first partial period discarded
    meas_ready = 1'b1;
    acc.delete();
    drive_wave(5, 3, 1);
    @(negedge clk);
    chk("one_rise_valid", meas_valid, 0);
    drive_wave(5, 3, 6);
    cyc(4);
    chk_acc("steady", 6, 8, 5);

    // backpressure on a 4/4 wave
    do_reset();
    meas_ready = 1'b0;
    acc.delete();
    drive_wave(4, 4, 3);
    cyc(4);
    @(negedge clk);
    chk("bp_valid", meas_valid, 1);
    chk("bp_period", period, 8);
    chk("bp_high", high_time, 4);
    chk("bp_overrun", overrun, 1);
    cyc(1);
    meas_ready = 1'b1;
    cyc(1);
    @(negedge clk);
    chk("bp_drop_valid", meas_valid, 0);
    chk("bp_keep_overrun", overrun, 1);
    chk_acc("bp_acc", 1, 8, 4);
    cyc(1);
    clr_overrun = 1'b1;
    cyc(1);
    clr_overrun = 1'b0;
    @(negedge clk);
    chk("bp_clr", overrun, 0);

    // stall: held high past saturation, then a 3/3 wave
    cyc(1);
    do_reset();
    acc.delete();
    blink_in = 1'b1;
    cyc(70);
    @(negedge clk);
    chk("stall_stuck", stuck, 1);
    chk("stall_valid", meas_valid, 0);
    blink_in = 1'b0;
    cyc(3);
    blink_in = 1'b1;
    cyc(3);
    @(negedge clk);
    chk("stall_clear", stuck, 0);
    blink_in = 1'b0;
    cyc(3);
    drive_wave(3, 3, 2);
    cyc(4);
    chk_acc("stall_wave", 2, 6, 3);

    // minimum pulse
    do_reset();
    acc.delete();
    cyc(2);
    drive_wave(1, 1, 8);
    cyc(4);
    chk_acc("minpulse", 7, 2, 1);

    // random-phase edges on a nominal 6/4 wave
    do_reset();
    acc.delete();
    cyc(2);
    @(negedge clk);
    base = $time;
    for (int p = 0; p < 12; p++) begin
      t = base + p * 100 + jit();
      #(t - $time);
      blink_in = 1'b1;
      t = base + p * 100 + 60 + jit();
      #(t - $time);
      blink_in = 1'b0;
    end
    cyc(6);
    chk("jit_count", acc.size(), 11);
    foreach (acc[i]) begin
      chk("jit_period", (acc[i].per >= 9 && acc[i].per <= 11), 1);
      chk("jit_high", (acc[i].hi >= 5 && acc[i].hi <= 7), 1);
    end

    // random segments, random ready and overrun clears
    do_reset();
    lvl = 1'b0;
    for (int seg = 0; seg < 40; seg++) begin
      lvl = ~lvl;
      len = ($urandom_range(0, 7) == 0) ? $urandom_range(58, 72) : $urandom_range(1, 20);
      blink_in = lvl;
      repeat (len) begin
        meas_ready  = ($urandom_range(0, 3) != 0);
        clr_overrun = ($urandom_range(0, 15) == 0);
        cyc(1);
      end
    end
    clr_overrun = 1'b0;
    meas_ready  = 1'b1;
    blink_in    = 1'b0;
    cyc(4);

    // reset during the low phase of a 5/3 wave
    do_reset();
    meas_ready = 1'b0;
    drive_wave(5, 3, 3);
    blink_in = 1'b1;
    cyc(5);
    blink_in = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("mid_pre_valid", meas_valid, 1);
    chk("mid_pre_overrun", overrun, 1);
    rst = 1'b0;
    cyc(1);
    @(negedge clk);
    chk("mid_rst_valid", meas_valid, 0);
    chk("mid_rst_period", period, 0);
    chk("mid_rst_high", high_time, 0);
    chk("mid_rst_overrun", overrun, 0);
    chk("mid_rst_stuck", stuck, 0);
    rst = 1'b1;
    cyc(1);
    meas_ready = 1'b1;
    acc.delete();
    cyc(1);
    drive_wave(5, 3, 3);
    cyc(4);
    chk_acc("mid_after", 2, 8, 5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
